// File: rtl/k_and_s_gen_if.sv
// Shared instruction/data memory port of the k_and_s_gen core.
// master = core side, slave = memory/bridge side.
interface k_and_s_gen_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // req/we/addr/wdata are held stable until the edge where req & ready;
    // that edge completes the access and samples rdata for reads.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/k_and_s_gen.sv
// Parametrised multi-cycle K&S-style core: FSM, register file, ALU, flags, one memory port.
// Optional K_AND_S_GEN_PERF_CNT_EN adds a 32-bit retired-instruction counter port.
module k_and_s_gen #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    k_and_s_gen_if.master        bus,
    output logic                 halt,
    output logic [2:0]           dbg_state
`ifdef K_AND_S_GEN_PERF_CNT_EN
    ,
    output logic [31:0]          retired
`endif
);
    localparam int RW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALTED} state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1, OP_STORE = 4'h2, OP_MOVE = 4'h3,
                           OP_ADD   = 4'h4, OP_SUB   = 4'h5, OP_AND  = 4'h6,
                           OP_OR    = 4'h7, OP_BR    = 4'h8, OP_BZ   = 4'h9,
                           OP_BNZ   = 4'hA, OP_BN    = 4'hB, OP_BNN  = 4'hC,
                           OP_BV    = 4'hD, OP_BNV   = 4'hE, OP_HALT = 4'hF;

    if (NUM_REGS < 2 || (1 << RW) != NUM_REGS ||
        DATA_W < 4 + 3 * RW || DATA_W < 4 + RW + ADDR_W) begin : g_bad_params
        $error("k_and_s_gen: illegal DATA_W/ADDR_W/NUM_REGS combination");
    end

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              flag_z, flag_n, flag_v;

    logic [3:0]        op;
    logic [RW-1:0]     rd, ra, rb;
    logic [ADDR_W-1:0] target;

    assign op        = ir[DATA_W-1 -: 4];
    assign rd        = ir[DATA_W-5 -: RW];
    assign ra        = ir[DATA_W-5-RW -: RW];
    assign rb        = ir[DATA_W-5-2*RW -: RW];
    assign target    = ir[ADDR_W-1:0];
    assign dbg_state = state;

    logic [DATA_W-1:0] opa, opb, alu_res;
    logic              alu_v, take, is_alu;

    // Operands come from the registers before this instruction's write-back,
    // so rd == ra/rb reads the old value.
    always_comb begin
        opa     = regs[ra];
        opb     = regs[rb];
        alu_res = opa;
        alu_v   = 1'b0;
        is_alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        case (op)
            OP_ADD: begin
                alu_res = opa + opb;
                alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = opa - opb;
                alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
            end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            default: alu_res = opa;
        endcase
        case (op)
            OP_BR:   take = 1'b1;
            OP_BZ:   take = flag_z;
            OP_BNZ:  take = !flag_z;
            OP_BN:   take = flag_n;
            OP_BNN:  take = !flag_n;
            OP_BV:   take = flag_v;
            OP_BNV:  take = !flag_v;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= '0;
            ir            <= '0;
            flag_z        <= 1'b0;
            flag_n        <= 1'b0;
            flag_v        <= 1'b0;
            halt          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Only the first FETCH after reset arrives with the request still low.
                    if (!bus.mem_req) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                    end else if (bus.mem_ready) begin
                        ir           <= bus.mem_rdata;
                        pc           <= pc + ADDR_W'(1);
                        bus.mem_req  <= 1'b0;
                        bus.mem_addr <= '0;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    if (op == OP_LOAD || op == OP_STORE) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= (op == OP_STORE);
                        bus.mem_addr  <= target;
                        bus.mem_wdata <= (op == OP_STORE) ? regs[rd] : '0;
                        state         <= MEM;
                    end else if (op == OP_HALT) begin
                        halt  <= 1'b1;
                        state <= HALTED;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_alu || op == OP_MOVE) regs[rd] <= alu_res;
                    if (is_alu) begin
                        flag_z <= (alu_res == '0);
                        flag_n <= alu_res[DATA_W-1];
                        flag_v <= alu_v;
                    end
                    if (take) pc <= target;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= take ? target : pc;
                    state        <= FETCH;
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (op == OP_LOAD) regs[rd] <= bus.mem_rdata;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        bus.mem_addr  <= pc;
                        state         <= FETCH;
                    end
                end
                HALTED: ;
                default: state <= FETCH;
            endcase
        end
    end

`ifdef K_AND_S_GEN_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (state == EXEC || (state == MEM && bus.mem_ready)) begin
            retired <= retired + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_k_and_s_gen.sv
// Scoreboard bench for k_and_s_gen: an ISA-level model predicts every memory access.
// Define K_AND_S_GEN_PERF_CNT_EN to also check the retired counter.
module tb_k_and_s_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_wrap_n = 1'b0;
    logic halt, w_halt;
    logic [2:0] dbg_state, w_dbg_state;
`ifdef K_AND_S_GEN_PERF_CNT_EN
    logic [31:0] retired, w_retired;
`endif

    always #5 clk = ~clk;

    k_and_s_gen_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    k_and_s_gen_if #(.DATA_W(16), .ADDR_W(4)) wbus ();

    k_and_s_gen #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halt(halt), .dbg_state(dbg_state)
`ifdef K_AND_S_GEN_PERF_CNT_EN
        , .retired(retired)
`endif
    );

    k_and_s_gen #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(4)) dut_wrap (
        .clk(clk), .rst_n(rst_wrap_n), .bus(wbus), .halt(w_halt), .dbg_state(w_dbg_state)
`ifdef K_AND_S_GEN_PERF_CNT_EN
        , .retired(w_retired)
`endif
    );

    assign wbus.mem_ready = 1'b1;
    assign wbus.mem_rdata = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [15:0] tb_mem [256];
    logic [15:0] mm [256];
    logic [25:0] exp_q [$];     // {is_fetch, we, addr, wdata}
    int fetch_cyc [$];
    int wait_lo = 0, wait_hi = 0;
    bit stall_we = 0;
    int exp_ret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int to_s(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Instruction-level interpreter: walks the program and lists every access.
    task automatic model_run(output int n_ret);
        logic [15:0] r [4];
        logic z, n, v, take;
        logic [7:0] pc, ad;
        logic [15:0] ir, res;
        logic [3:0] op;
        logic [1:0] rd, ra, rb;
        int s;
        for (int i = 0; i < 4; i++) r[i] = 16'h0;
        z = 0; n = 0; v = 0; pc = 8'h00; n_ret = 0;
        for (int step = 0; step < 3000; step++) begin
            ir = mm[pc];
            exp_q.push_back({1'b1, 1'b0, pc, 16'h0000});
            pc = pc + 8'd1;
            op = ir[15:12]; rd = ir[11:10]; ra = ir[9:8]; rb = ir[7:6]; ad = ir[7:0];
            if (op == 4'hF) break;
            n_ret++;
            case (op)
                4'h1: begin exp_q.push_back({1'b0, 1'b0, ad, 16'h0000}); r[rd] = mm[ad]; end
                4'h2: begin exp_q.push_back({1'b0, 1'b1, ad, r[rd]}); mm[ad] = r[rd]; end
                4'h3: r[rd] = r[ra];
                4'h4, 4'h5, 4'h6, 4'h7: begin
                    if (op == 4'h4) s = to_s(r[ra]) + to_s(r[rb]);
                    else if (op == 4'h5) s = to_s(r[ra]) - to_s(r[rb]);
                    else s = 0;
                    if (op == 4'h6) res = r[ra] & r[rb];
                    else if (op == 4'h7) res = r[ra] | r[rb];
                    else res = s[15:0];
                    v = (op <= 4'h5) && (s > 32767 || s < -32768);
                    z = (res == 16'h0000);
                    n = (res >= 16'h8000);
                    r[rd] = res;
                end
                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                    case (op)
                        4'h8: take = 1;
                        4'h9: take = z;
                        4'hA: take = !z;
                        4'hB: take = n;
                        4'hC: take = !n;
                        4'hD: take = v;
                        default: take = !v;
                    endcase
                    if (take) pc = ad;
                end
                default: ;
            endcase
        end
    endtask

    // Memory responder plus monitor: one process so ready and the check see the same cycle.
    int wcnt = 0;
    bit in_access = 0, pend = 0, rdy;
    logic [40:0] held, cur;
    logic [25:0] e;
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (!in_access) wcnt = $urandom_range(wait_hi, wait_lo);
            rdy = (wcnt == 0) && !(stall_we && bus.mem_we);
            if (!rdy && wcnt > 0) wcnt--;
            in_access = !rdy;
        end else begin
            rdy = 1'($urandom_range(0, 1));
            in_access = 0;
        end
        bus.mem_ready = rdy;
        bus.mem_rdata = rdy ? tb_mem[bus.mem_addr] : 16'($urandom);
        cur = {16'h0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        if (!bus.mem_req) check("idle_outputs", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'h0);
        if (pend && rst_n) check("req_hold", cur[31:0], held[31:0]);
        pend = rst_n && bus.mem_req && !rdy;
        held = cur;
        if (rst_n && bus.mem_req && rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_access: got addr %h we %b expected none", bus.mem_addr, bus.mem_we);
            end else begin
                e = exp_q.pop_front();
                check("mem_access", 32'({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0}),
                      32'(e[24:0]));
                if (e[25]) fetch_cyc.push_back(cyc);
            end
            if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Wrap instance: all-NOP memory, so every access is a fetch of the next pc.
    int wrap_n = 0;
    always @(negedge clk) begin
        if (rst_wrap_n && wbus.mem_req && wrap_n < 40) begin
            check("pc_wrap_fetch", 32'({wbus.mem_we, wbus.mem_addr}), 32'(wrap_n % 16));
            wrap_n++;
        end
    end

    task automatic start_program();
        rst_n = 1'b0;
        exp_q.delete();
        fetch_cyc.delete();
        mm = tb_mem;
        model_run(exp_ret);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, halt}), 32'h0);
`ifdef K_AND_S_GEN_PERF_CNT_EN
        check("reset_retired", retired, 32'h0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic finish_program(input string name);
        int budget;
        for (budget = 0; budget < 20000; budget++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (budget >= 20000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got %0d pending accesses expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #1 check("halt_low_in_decode", 32'(halt), 32'h0);
        @(negedge clk);
        #1 check("halt_rise", 32'(halt), 32'h1);
`ifdef K_AND_S_GEN_PERF_CNT_EN
        check("retired_count", retired, 32'(exp_ret));
`endif
        repeat (4) @(negedge clk);
        #1 check("halt_sticky", 32'(halt), 32'h1);
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) tb_mem[a] = 16'h0000;
    endtask

    task automatic gen_random();
        logic [3:0] op;
        logic [15:0] w;
        clear_mem();
        for (int i = 0; i < 48; i++) begin
            op = 4'($urandom_range(0, 14));
            w = {op, 12'($urandom)};
            if (op == 4'h1 || op == 4'h2) w[7:0] = 8'($urandom_range(8'hCF, 8'hC0));
            if (op >= 4'h8) w[7:0] = 8'($urandom_range(48, i + 1));
            tb_mem[i] = w;
        end
        for (int r = 0; r < 4; r++) tb_mem[48 + r] = {4'h2, 2'(r), 2'b00, 8'(8'hF0 + r)};
        tb_mem[52] = 16'hF000;
        for (int a = 8'hC0; a <= 8'hCF; a++) tb_mem[a] = rand_data();
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        #12 rst_wrap_n = 1'b1;

        // Zero-wait LOAD/LOAD/ADD/STORE/HALT
        clear_mem();
        tb_mem[0] = 16'h1010; tb_mem[1] = 16'h1411; tb_mem[2] = 16'h4840;
        tb_mem[3] = 16'h2812; tb_mem[4] = 16'hF000;
        tb_mem[8'h10] = 16'd5; tb_mem[8'h11] = 16'd3;
        wait_lo = 0; wait_hi = 0;
        start_program();
        finish_program("basic");
        check("basic_sum", 32'(tb_mem[8'h12]), 32'd8);
        for (int i = 1; i < fetch_cyc.size(); i++)
            check("zero_wait_3cyc", 32'(fetch_cyc[i] - fetch_cyc[i-1]), 32'd3);

        // Signed overflow then BOV to 0x20
        clear_mem();
        tb_mem[0] = 16'h1014; tb_mem[1] = 16'h1415; tb_mem[2] = 16'h4840;
        tb_mem[3] = 16'hD020; tb_mem[8'h20] = 16'h2813; tb_mem[8'h21] = 16'hF000;
        tb_mem[8'h14] = 16'h7FFF; tb_mem[8'h15] = 16'h0001;
        start_program();
        finish_program("overflow");
        check("overflow_sum", 32'(tb_mem[8'h13]), 32'h8000);

        // Four wait states on every access: NOP takes 7 cycles
        clear_mem();
        tb_mem[0] = 16'h0000; tb_mem[1] = 16'hF000;
        wait_lo = 4; wait_hi = 4;
        start_program();
        finish_program("waits");
        if (fetch_cyc.size() == 2) check("nop_wait_7cyc", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd7);
        else check("nop_wait_fetches", 32'(fetch_cyc.size()), 32'd2);

        // Reset while a STORE is stalled
        clear_mem();
        tb_mem[0] = 16'h1440; tb_mem[1] = 16'h2441; tb_mem[2] = 16'hF000;
        tb_mem[8'h40] = 16'h1234;
        wait_lo = 0; wait_hi = 1; stall_we = 1;
        start_program();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req && bus.mem_we) break;
        end
        repeat (3) @(negedge clk);
        #1 check("stalled_store", 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'h3_41_1234);
        #1 rst_n = 1'b0;
        #1 check("async_req_drop", 32'(bus.mem_req), 32'h0);
        stall_we = 0;
        check("aborted_write", 32'(tb_mem[8'h41]), 32'h0);
        tb_mem[0] = 16'h2442; tb_mem[1] = 16'hF000; tb_mem[8'h42] = 16'hFFFF;
        start_program();
        finish_program("after_reset");
        check("regs_cleared", 32'(tb_mem[8'h42]), 32'h0);

        // Random programs against the interpreter
        for (int t = 0; t < 8; t++) begin
            gen_random();
            wait_lo = 0; wait_hi = t % 4;
            start_program();
            finish_program("random");
        end

        repeat (5) @(negedge clk);
        check("wrap_fetch_count", 32'(wrap_n), 32'd40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL global_timeout: got no completion expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end
endmodule
